// File: rtl/rot_pkg.sv
// Shared types and constants for the rotary-step sequencer.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } rot_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Width of a down-counter that must hold values up to cyc-1.
    function automatic int unsigned gap_cnt_w(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/rot_pos_reg.sv
// Bounded position register: saturates or wraps at 0 and POS_MAX.
module rot_pos_reg
    import rot_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int POS_MAX = 255,
    parameter int WRAP    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0] MAX_V = POS_W'(POS_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (inc) begin
            if (pos == MAX_V) begin
                pos <= (WRAP != 0) ? '0 : pos;
            end else begin
                pos <= pos + 1'b1;
            end
        end else if (dec) begin
            if (pos == '0) begin
                pos <= (WRAP != 0) ? MAX_V : pos;
            end else begin
                pos <= pos - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rot_step_ctrl.sv
// Rotary event sequencer: edge-detects encoder events, tracks position and
// delivers buffered net steps over a rate-limited valid/ready handshake.
module rot_step_ctrl
    import rot_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int POS_MAX = 255,
    parameter int WRAP    = 0,
    parameter int PEND_W  = 4,
    parameter int GAP_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             rot_event,
    input  logic             rot_left,
    output logic             step_valid,
    output logic             step_dir,
    input  logic             step_ready,
    output logic [POS_W-1:0] pos,
    output logic             pend_ovf,
    output logic             busy
);

    localparam int PEND_LIM = (1 << (PEND_W - 1)) - 1;
    localparam int GAP_W    = gap_cnt_w(GAP_CYC);
    localparam int SUM_W    = PEND_W + 2;

    localparam logic signed [SUM_W-1:0] LIM_P = SUM_W'(PEND_LIM);
    localparam logic signed [SUM_W-1:0] LIM_N = -LIM_P;

    logic                     rot_event_q;
    logic                     ev;
    logic                     take;
    logic                     ev_ovf;
    logic signed [PEND_W-1:0] pend;
    logic signed [PEND_W-1:0] pend_nx;
    logic signed [PEND_W-1:0] take_n;
    logic signed [SUM_W-1:0]  ev_d;
    logic signed [SUM_W-1:0]  sum_all;

    rot_state_t       state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             dir_q, dir_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_event_q <= 1'b0;
        end else begin
            rot_event_q <= rot_event;
        end
    end

    assign ev = en & rot_event & ~rot_event_q;

    rot_pos_reg #(
        .POS_W   (POS_W),
        .POS_MAX (POS_MAX),
        .WRAP    (WRAP)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (ev & ~rot_left),
        .dec   (ev & rot_left),
        .pos   (pos)
    );

    // An event that would push pend past the limit is dropped from pend only;
    // a concurrent latch still removes its step.
    always_comb begin
        ev_d   = '0;
        take_n = '0;
        if (ev) begin
            ev_d = rot_left ? '1 : SUM_W'(1);
        end
        if (take) begin
            take_n = pend[PEND_W-1] ? '1 : PEND_W'(1);
        end
        sum_all = {{2{pend[PEND_W-1]}}, pend} + ev_d - {{2{take_n[PEND_W-1]}}, take_n};
        ev_ovf  = ev & ((sum_all > LIM_P) | (sum_all < LIM_N));
        if (ev_ovf) begin
            pend_nx = pend - take_n;
        end else begin
            pend_nx = sum_all[PEND_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_ovf <= 1'b0;
        end else if (clr) begin
            pend     <= '0;
            pend_ovf <= 1'b0;
        end else begin
            pend <= pend_nx;
            if (ev_ovf) begin
                pend_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
        end
    end

    // A clear in IDLE wins over latching, so nothing is offered after clr.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        dir_d   = dir_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((pend != '0) && !clr) begin
                    take    = 1'b1;
                    dir_d   = pend[PEND_W-1] ? DIR_LEFT : DIR_RIGHT;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (step_ready) begin
                    gap_d   = GAP_W'(GAP_CYC - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step_valid = (state_q == OFFER);
    assign step_dir   = dir_q;
    assign busy       = (state_q != IDLE) || (pend != '0);

endmodule
